// File: rtl/muldiv_unit_if.sv
// Execute-stage multiply/divide request and result bundle.
// The master side is the pipeline (issues requests, reads HI/LO). The slave side is the unit.
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  StartE;
  logic [1:0]            MulDivOpE;
  logic [DATA_WIDTH-1:0] SrcAE;
  logic [DATA_WIDTH-1:0] SrcBE;
  logic                  FlushE;
  logic                  BusyE;
  logic                  DoneE;
  logic [DATA_WIDTH-1:0] HiOut;
  logic [DATA_WIDTH-1:0] LoOut;

  modport master (
    output StartE, MulDivOpE, SrcAE, SrcBE, FlushE,
    input  BusyE, DoneE, HiOut, LoOut
  );

  modport slave (
    input  StartE, MulDivOpE, SrcAE, SrcBE, FlushE,
    output BusyE, DoneE, HiOut, LoOut
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned MULTU/DIVU unit that owns the architectural HI/LO registers.
// It retires one bit per cycle. HI/LO are written only on completion, so partial
// accumulator and remainder values never reach the MFHI/MFLO path.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10
  } state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt;
  // MUL: opA = multiplicand, opB = multiplier, shifted right each step.
  // DIV: opA = dividend, which turns into the quotient, opB = divisor.
  logic [W-1:0]     opA, opB, rem;
  logic [2*W:0]     acc;          // includes the extra carry bit
  logic [W-1:0]     hiReg, loReg;
  logic             busyReg, doneReg;

  logic [W:0]       mulSum;
  logic [2*W:0]     accNext;
  logic [W:0]       divTrial;
  logic [W-1:0]     divDiff, remNext, quoNext;
  logic             divGe, lastIter;
  logic             busyNext, doneNext;
  logic [W-1:0]     hiNext, loNext;

  // One shift-add multiply step and one restoring divide step, evaluated every cycle
  always_comb begin
    if (opB[0]) begin
      mulSum = acc[2*W:W] + {1'b0, opA};
    end else begin
      mulSum = acc[2*W:W];
    end
    accNext  = {1'b0, mulSum, acc[W-1:1]};
    divTrial = {rem, opA[W-1]};
    divGe    = (divTrial >= {1'b0, opB});
    // When the trial is at least the divisor, the true difference fits in W bits.
    divDiff  = divTrial[W-1:0] - opB;
    if (divGe) begin
      remNext = divDiff;
    end else begin
      remNext = divTrial[W-1:0];
    end
    quoNext  = {opA[W-2:0], divGe};
    lastIter = (cnt == CNT_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state: start decode in IDLE, terminal count or flush while iterating
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (bus.FlushE || !bus.StartE) begin
          stateNext = IDLE;
        end else if (bus.MulDivOpE == OP_MULTU) begin
          stateNext = MUL;
        end else if (bus.MulDivOpE == OP_DIVU) begin
          stateNext = DIV;
        end else begin
          stateNext = IDLE;
        end
      end
      MUL, DIV: begin
        if (bus.FlushE || lastIter) begin
          stateNext = IDLE;
        end else begin
          stateNext = state;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Output decode: next Busy/Done and HI/LO write values (flush suppresses writes)
  always_comb begin
    busyNext = (stateNext != IDLE);
    doneNext = 1'b0;
    hiNext   = hiReg;
    loNext   = loReg;
    case (state)
      IDLE: begin
        if (!bus.FlushE && bus.StartE && (bus.MulDivOpE == OP_MTHI)) begin
          hiNext = bus.SrcAE;
        end else if (!bus.FlushE && bus.StartE && (bus.MulDivOpE == OP_MTLO)) begin
          loNext = bus.SrcAE;
        end else begin
          hiNext = hiReg;
        end
      end
      MUL: begin
        if (!bus.FlushE && lastIter) begin
          doneNext = 1'b1;
          hiNext   = accNext[2*W-1:W];
          loNext   = accNext[W-1:0];
        end else begin
          doneNext = 1'b0;
        end
      end
      DIV: begin
        if (!bus.FlushE && lastIter) begin
          doneNext = 1'b1;
          hiNext   = remNext;
          loNext   = quoNext;
        end else begin
          doneNext = 1'b0;
        end
      end
      default: doneNext = 1'b0;
    endcase
  end

  // Datapath, iteration counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      opA     <= '0;
      opB     <= '0;
      rem     <= '0;
      acc     <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      busyReg <= busyNext;
      doneReg <= doneNext;
      hiReg   <= hiNext;
      loReg   <= loNext;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (stateNext == MUL) begin
            opA <= bus.SrcAE;
            opB <= bus.SrcBE;
            acc <= '0;
          end else if (stateNext == DIV) begin
            opA <= bus.SrcAE;
            opB <= bus.SrcBE;
            rem <= '0;
          end else begin
            acc <= acc;
          end
        end
        MUL: begin
          acc <= accNext;
          opB <= opB >> 1;
          cnt <= (stateNext == IDLE) ? '0 : cnt + CNT_W'(1);
        end
        DIV: begin
          rem <= remNext;
          opA <= quoNext;
          cnt <= (stateNext == IDLE) ? '0 : cnt + CNT_W'(1);
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign bus.BusyE = busyReg;
  assign bus.DoneE = doneReg;
  assign bus.HiOut = hiReg;
  assign bus.LoOut = loReg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {HI,LO} is queued at issue and checked on DoneE.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if #(.DATA_WIDTH(32)) bus();
  muldiv_unit #(.DATA_WIDTH(32)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sbQ[$];
  logic [31:0] hiModel = 32'h0;
  logic [31:0] loModel = 32'h0;

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 2'b00) return {32'h0, a} * {32'h0, b};
    else if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    else return {a % b, a / b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.StartE = 1'b1; bus.MulDivOpE = op; bus.SrcAE = a; bus.SrcBE = b;
    tick();
    bus.StartE = 1'b0;
  endtask

  task automatic wait_not_busy(output int cycles);
    cycles = 0;
    while (bus.BusyE === 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    bus.StartE = 1'b1; bus.MulDivOpE = 2'b00; bus.SrcAE = 32'd3; bus.SrcBE = 32'd4; bus.FlushE = 1'b0;
    rst = 1'b1;
    tick(); tick();
    bus.StartE = 1'b0;
    rst = 1'b0;
    vectors++; if (bus.BusyE !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%0b exp=0", bus.BusyE); end
    vectors++; if (bus.DoneE !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%0b exp=0", bus.DoneE); end
    vectors++; if (bus.HiOut !== 32'h0) begin miscompares++; $display("FAIL reset_hi got=%0h exp=0", bus.HiOut); end
    vectors++; if (bus.LoOut !== 32'h0) begin miscompares++; $display("FAIL reset_lo got=%0h exp=0", bus.LoOut); end
  endtask

  task automatic test_arith();
    logic [1:0]  tOp[9];
    logic [31:0] tA[9];
    logic [31:0] tB[9];
    logic [63:0] exp;
    int cyc;
    tOp = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    tA  = '{32'd7, 32'hFFFF_FFFF, 32'h0, $urandom, 32'd100, 32'd5, 32'hFFFF_FFFF, 32'd7, $urandom};
    tB  = '{32'd6, 32'hFFFF_FFFF, 32'h1234_5678, $urandom, 32'd7, 32'd0, 32'd1, 32'd100, $urandom_range(1, 32'h0000_FFFF)};
    for (int i = 0; i < 9; i++) begin
      sbQ.push_back(model(tOp[i], tA[i], tB[i]));
      start_op(tOp[i], tA[i], tB[i]);
      wait_not_busy(cyc);
      vectors++; if (cyc !== 32) begin miscompares++; $display("FAIL arith_busy_cycles[%0d] got=%0d exp=32", i, cyc); end
      vectors++; if (bus.DoneE !== 1'b1) begin miscompares++; $display("FAIL arith_done[%0d] got=%0b exp=1", i, bus.DoneE); end
      exp = (sbQ.size() > 0) ? sbQ.pop_front() : 64'hX;
      vectors++; if ({bus.HiOut, bus.LoOut} !== exp) begin miscompares++; $display("FAIL arith_hilo[%0d] got=%h exp=%h", i, {bus.HiOut, bus.LoOut}, exp); end
      {hiModel, loModel} = exp;
      tick();
      vectors++; if (bus.DoneE !== 1'b0) begin miscompares++; $display("FAIL arith_done_pulse[%0d] got=%0b exp=0", i, bus.DoneE); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    int cyc;
    for (int i = 0; i < 3; i++) begin
      logic [1:0]  op = (i == 1) ? 2'b01 : 2'b00;
      logic [31:0] a  = $urandom;
      logic [31:0] b  = $urandom_range(1, 32'h00FF_FFFF);
      sbQ.push_back(model(op, a, b));
      start_op(op, a, b);
      if (i > 0) begin
        vectors++; if (bus.DoneE !== 1'b0 || bus.BusyE !== 1'b1) begin miscompares++; $display("FAIL b2b_restart[%0d] got busy=%0b done=%0b exp busy=1 done=0", i, bus.BusyE, bus.DoneE); end
      end
      wait_not_busy(cyc);
      vectors++; if (cyc !== 32) begin miscompares++; $display("FAIL b2b_busy_cycles[%0d] got=%0d exp=32", i, cyc); end
      exp = (sbQ.size() > 0) ? sbQ.pop_front() : 64'hX;
      vectors++; if (bus.DoneE !== 1'b1 || {bus.HiOut, bus.LoOut} !== exp) begin miscompares++; $display("FAIL b2b_result[%0d] got done=%0b hilo=%h exp done=1 hilo=%h", i, bus.DoneE, {bus.HiOut, bus.LoOut}, exp); end
      {hiModel, loModel} = exp;
    end
    tick();
  endtask

  task automatic test_mt_flush();
    start_op(2'b10, 32'h0000_1234, 32'hDEAD_BEEF);
    hiModel = 32'h0000_1234;
    vectors++; if (bus.HiOut !== hiModel || bus.BusyE !== 1'b0 || bus.DoneE !== 1'b0) begin miscompares++; $display("FAIL mthi got hi=%0h busy=%0b done=%0b exp hi=%0h busy=0 done=0", bus.HiOut, bus.BusyE, bus.DoneE, hiModel); end
    start_op(2'b11, 32'h0000_5678, 32'hDEAD_BEEF);
    loModel = 32'h0000_5678;
    vectors++; if (bus.LoOut !== loModel || bus.HiOut !== hiModel || bus.BusyE !== 1'b0 || bus.DoneE !== 1'b0) begin miscompares++; $display("FAIL mtlo got hi=%0h lo=%0h busy=%0b done=%0b exp hi=%0h lo=%0h", bus.HiOut, bus.LoOut, bus.BusyE, bus.DoneE, hiModel, loModel); end
    start_op(2'b00, 32'd3, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    bus.FlushE = 1'b1;
    tick();
    bus.FlushE = 1'b0;
    vectors++; if (bus.BusyE !== 1'b0) begin miscompares++; $display("FAIL flush_busy got=%0b exp=0", bus.BusyE); end
    vectors++; if (bus.HiOut !== 32'h1234 || bus.LoOut !== 32'h5678) begin miscompares++; $display("FAIL flush_hilo got=%h exp=%h", {bus.HiOut, bus.LoOut}, {hiModel, loModel}); end
    for (int i = 0; i < 30; i++) begin
      if (bus.DoneE !== 1'b0) begin vectors++; miscompares++; $display("FAIL flush_no_done got=1 exp=0 at cycle %0d", i); end
      tick();
    end
    vectors++; if (bus.DoneE !== 1'b0 || bus.LoOut !== loModel) begin miscompares++; $display("FAIL flush_quiet got done=%0b lo=%0h exp done=0 lo=%0h", bus.DoneE, bus.LoOut, loModel); end
  endtask

  task automatic test_start_collision();
    logic [63:0] exp;
    int cyc;
    sbQ.push_back(model(2'b00, 32'h0001_2345, 32'h0000_0777));
    start_op(2'b00, 32'h0001_2345, 32'h0000_0777);
    for (int i = 0; i < 5; i++) tick();
    bus.StartE = 1'b1; bus.MulDivOpE = 2'b01; bus.SrcAE = 32'd99; bus.SrcBE = 32'd4;
    tick();
    bus.StartE = 1'b0;
    wait_not_busy(cyc);
    cyc = cyc + 6;
    vectors++; if (cyc !== 32) begin miscompares++; $display("FAIL collide_busy_cycles got=%0d exp=32", cyc); end
    exp = (sbQ.size() > 0) ? sbQ.pop_front() : 64'hX;
    vectors++; if (bus.DoneE !== 1'b1 || {bus.HiOut, bus.LoOut} !== exp) begin miscompares++; $display("FAIL collide_result got done=%0b hilo=%h exp done=1 hilo=%h", bus.DoneE, {bus.HiOut, bus.LoOut}, exp); end
    {hiModel, loModel} = exp;
    tick();
    vectors++; if (bus.BusyE !== 1'b0 || bus.DoneE !== 1'b0) begin miscompares++; $display("FAIL collide_no_queue got busy=%0b done=%0b exp 0 0", bus.BusyE, bus.DoneE); end
  endtask

  task automatic test_flush_last();
    start_op(2'b10, 32'hAAAA_0000, 32'h0);
    start_op(2'b11, 32'h0000_5555, 32'h0);
    hiModel = 32'hAAAA_0000; loModel = 32'h0000_5555;
    start_op(2'b00, 32'd9, 32'd9);
    for (int i = 0; i < 31; i++) tick();
    vectors++; if (bus.BusyE !== 1'b1) begin miscompares++; $display("FAIL flast_still_busy got=%0b exp=1", bus.BusyE); end
    bus.FlushE = 1'b1;
    tick();
    bus.FlushE = 1'b0;
    vectors++; if (bus.BusyE !== 1'b0 || bus.DoneE !== 1'b0) begin miscompares++; $display("FAIL flast_state got busy=%0b done=%0b exp 0 0", bus.BusyE, bus.DoneE); end
    vectors++; if ({bus.HiOut, bus.LoOut} !== {hiModel, loModel}) begin miscompares++; $display("FAIL flast_hilo got=%h exp=%h", {bus.HiOut, bus.LoOut}, {hiModel, loModel}); end
    tick();
    vectors++; if (bus.DoneE !== 1'b0) begin miscompares++; $display("FAIL flast_late_done got=%0b exp=0", bus.DoneE); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] exp;
    int cyc;
    start_op(2'b01, 32'd1000, 32'd3);
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hiModel = 32'h0; loModel = 32'h0;
    vectors++; if (bus.BusyE !== 1'b0 || bus.DoneE !== 1'b0) begin miscompares++; $display("FAIL rstmid_state got busy=%0b done=%0b exp 0 0", bus.BusyE, bus.DoneE); end
    vectors++; if ({bus.HiOut, bus.LoOut} !== 64'h0) begin miscompares++; $display("FAIL rstmid_hilo got=%h exp=0", {bus.HiOut, bus.LoOut}); end
    sbQ.push_back(model(2'b00, 32'd2, 32'd5));
    start_op(2'b00, 32'd2, 32'd5);
    wait_not_busy(cyc);
    vectors++; if (cyc !== 32) begin miscompares++; $display("FAIL rstmid_busy_cycles got=%0d exp=32", cyc); end
    exp = (sbQ.size() > 0) ? sbQ.pop_front() : 64'hX;
    vectors++; if (bus.DoneE !== 1'b1 || {bus.HiOut, bus.LoOut} !== exp) begin miscompares++; $display("FAIL rstmid_mul got done=%0b hilo=%h exp done=1 hilo=%h", bus.DoneE, {bus.HiOut, bus.LoOut}, exp); end
    tick();
  endtask

  initial begin
    bus.StartE = 1'b0; bus.MulDivOpE = 2'b00; bus.SrcAE = 32'h0; bus.SrcBE = 32'h0; bus.FlushE = 1'b0;
    test_reset();
    test_arith();
    test_back_to_back();
    test_mt_flush();
    test_start_collision();
    test_flush_last();
    test_reset_mid();
    vectors++; if (sbQ.size() !== 0) begin miscompares++; $display("FAIL scoreboard_drain got=%0d exp=0", sbQ.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
